spi_arbiter: RTL
================

# spi_arbiter

Round-robin arbiter and transaction sequencer that shares one `SPImaster` between `NREQ` requesters. Each requester posts a single-byte write or read; the arbiter grants one at a time and drives the master's `start_tx`/`start_rx`/`data_tx`. It times the byte with an internal counter, because the master has no done flag. It returns captured `data_rx` and an ack pulse to the granted requester. The block sits between the on-chip clients and `SPImaster` in the SPI subsystem.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (1..8)
- `BYTE_CYCLES`, 20, clk cycles the start level is held for one full byte on `SPImaster` (≥ 2)
- `GAP_CYCLES`, 2, idle clk cycles between transactions with both starts low (≥ 1)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous reset, active-high
- `req`  in  NREQ  per-requester transaction request, level
- `is_read`  in  NREQ  per-requester: 1 = read (`start_rx`), 0 = write (`start_tx`)
- `wdata`  in  8*NREQ  per-requester write byte; requester i uses bits [8i+7:8i]
- `ack`  out  NREQ  one-hot, one-cycle completion pulse
- `rdata`  out  8  byte captured from `spi_data_rx`; valid in the `ack` cycle, held until the next ack
- `grant`  out  NREQ  one-hot owner of the current transaction; 0 when idle
- `busy`  out  1  high from the grant cycle through the end of GAP
- `spi_start_tx`  out  1  to `SPImaster.start_tx`
- `spi_start_rx`  out  1  to `SPImaster.start_rx`
- `spi_data_tx`  out  8  to `SPImaster.data_tx`
- `spi_data_rx`  in  8  from `SPImaster.data_rx`

## Operation
- FSM states: IDLE, XFER, DONE, GAP.
- **IDLE:** when any `req` bit is high, choose the winner by round robin and move to XFER. The search starts at pointer `ptr` and wraps modulo NREQ. In that transition edge:
  - register `grant`;
  - latch `wdata` of the winner into `spi_data_tx`;
  - latch its `is_read` into the internal `op` register;
  - load the counter with BYTE_CYCLES-1.
- **XFER:** drive `spi_start_rx = op` and `spi_start_tx = ~op`. Never assert both. Decrement the counter each cycle. At 0, go to DONE.
- **DONE (one cycle):**
  - both starts low;
  - `ack` = `grant`;
  - `rdata` ← `spi_data_rx`, also on writes, because the master's full-duplex data is returned;
  - `ptr` ← winner index + 1, mod NREQ;
  - load the counter with GAP_CYCLES-1;
  - go to GAP.
- **GAP:** both starts low, `grant` held, `busy` high. At counter 0, clear `grant` and go to IDLE.
- `req`, `is_read` and `wdata` are sampled only in IDLE. Changes during a transaction are ignored.
- If the winner drops `req` mid-transaction, the transaction still completes and its `ack` still pulses.
- A requester that holds `req` after its `ack` is treated as a new request. With other requesters pending, it waits behind them (fairness). As the sole requester, it is served back to back with only GAP between transactions.
- `spi_data_tx` is held stable for the whole of XFER.

## Timing
- **Reset (async):** all outputs are 0, `ptr` = 0, state IDLE. Reset mid-XFER drops the starts immediately, gives no `ack`, and discards the transaction.
- **Latency:** `req` seen high at edge N → `grant`/start high from N+1. Start is high for exactly BYTE_CYCLES cycles. `ack` is high in cycle N+1+BYTE_CYCLES. IDLE is re-entered at N+2+BYTE_CYCLES+GAP_CYCLES.
- **Throughput:** one byte per 2+BYTE_CYCLES+GAP_CYCLES cycles under continuous load.
- **Simultaneous requests:** resolved purely by `ptr`. Index i is served within NREQ transactions of asserting `req`.
- **NREQ = 1:** the pointer is a constant 0, and the internal index width is max(1, $clog2(NREQ)).

## Structure
- Shared package `spi_pkg` holds:
  - the FSM state encoding (`ST_IDLE`, `ST_XFER`, `ST_DONE`, `ST_GAP`, 2 bits);
  - the default `BYTE_CYCLES` and `GAP_CYCLES` constants, reused by `SPImaster` benches.
- The round-robin priority pick is a combinational sub-module, `rr_pick` (inputs `req` and `ptr`; outputs a one-hot winner and its index). It is reusable by other arbiters.

## Test plan
- **Single write:** reset, then `req`=0001, `is_read`=0, `wdata[7:0]`=8'hAA → `spi_start_tx` high 20 cycles, `spi_data_tx`=AA, `spi_start_rx`=0, `ack`=0001 one cycle later, `busy` low 3 cycles after the ack.
- **Single read:** `req`=0100, `is_read`=0100, slave MISO held at 1 → `spi_start_rx` high 20 cycles, `ack`=0100, `rdata`=8'hFF.
- **Contention:** `req`=1111 held continuously from reset → grant order 0001, 0010, 0100, 1000, 0001; each ack 24 cycles apart.
- **Fairness after wrap:** `ptr`=3, `req`=1001 → grant 1000 first, then 0001.
- **Request dropped:** the winner drops `req` 5 cycles into XFER → the starts still last 20 cycles and `ack` still pulses.
- **Reset mid-XFER:** assert `rst` 10 cycles into XFER → starts, `grant`, `busy` and `ack` go to 0 immediately. After release, a pending request is granted starting from `ptr`=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI subsystem constants: arbiter FSM encoding and default byte/gap timing.
package spi_pkg;

  // Arbiter FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // clk cycles the start level is held for one full byte on SPImaster
  localparam int unsigned DEFAULT_BYTE_CYCLES = 20;
  // idle clk cycles between transactions with both starts low
  localparam int unsigned DEFAULT_GAP_CYCLES  = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic           found;
  int unsigned    off;

  // Rotate requests so bit 0 sits at ptr, then take the lowest set bit as the offset.
  always_comb begin
    dbl   = {req, req} >> ptr;
    found = 1'b0;
    off   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
  end

  // Map the rotated offset back to an absolute index and one-hot winner.
  always_comb begin
    int unsigned sum;
    sum = 32'(ptr) + off;
    if (sum >= N) begin
      sum = sum - N;
    end
    idx = IW'(sum);
    win = '0;
    for (int unsigned i = 0; i < N; i++) begin
      win[i] = found && (sum == i);
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPImaster between NREQ single-byte requesters.
// The master has no done flag, so each byte is timed with an internal counter.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned BYTE_CYCLES = DEFAULT_BYTE_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   is_read,
  input  logic [8*NREQ-1:0] wdata,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        rdata,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              spi_start_tx,
  output logic              spi_start_rx,
  output logic [7:0]        spi_data_tx,
  input  logic [7:0]        spi_data_rx
);

  localparam int unsigned IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_MAX = (BYTE_CYCLES > GAP_CYCLES) ? BYTE_CYCLES : GAP_CYCLES;
  // Counter only ever holds values up to CNT_MAX-1.
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic            op_q, op_d;
  logic [7:0]      data_tx_q, data_tx_d;
  logic [7:0]      rdata_q, rdata_d;

  logic [NREQ-1:0] pick_win;
  logic [IW-1:0]   pick_idx;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .win (pick_win),
    .idx (pick_idx)
  );

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    op_d      = op_q;
    data_tx_d = data_tx_q;
    rdata_d   = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          grant_d   = pick_win;
          idx_d     = pick_idx;
          op_d      = is_read[pick_idx];
          data_tx_d = wdata[{pick_idx, 3'b000} +: 8];
          cnt_d     = CW'(BYTE_CYCLES - 1);
          state_d   = ST_XFER;
        end
      end
      ST_XFER: begin
        if (cnt_q == '0) begin
          // Capture on entry to DONE so rdata is already valid in the ack cycle.
          rdata_d = spi_data_rx;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
        cnt_d   = CW'(GAP_CYCLES - 1);
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; async reset discards any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      grant_q   <= '0;
      op_q      <= 1'b0;
      data_tx_q <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      op_q      <= op_d;
      data_tx_q <= data_tx_d;
      rdata_q   <= rdata_d;
    end
  end

  // Outputs decoded from registered state so reset clears them at once.
  always_comb begin
    ack          = (state_q == ST_DONE) ? grant_q : '0;
    busy         = (state_q != ST_IDLE);
    spi_start_rx = (state_q == ST_XFER) && op_q;
    spi_start_tx = (state_q == ST_XFER) && !op_q;
    grant        = grant_q;
    spi_data_tx  = data_tx_q;
    rdata        = rdata_q;
  end

endmodule
